result_streamer: RTL and testbench

RESULT_STREAMER -- requirements
Module: result_streamer

---
 rtl/result_streamer.sv | 177 +++++++++++++++++
 tb/tb_result_streamer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_streamer.sv
// result_streamer
//    Captures a complete N x N complex matrix on a single in_valid pulse and
//    streams it out one element per accepted transfer (valid/ready), in
//    row-major order. An in_valid arriving while a matrix is still streaming
//    is dropped and latches the sticky overrun flag, except when it coincides
//    with the transfer of the final element: then the new matrix is captured
//    and streaming restarts at (0,0) without a bubble.
//
//    Build option: define RESULT_STREAMER_HERMITIAN_EN to stream only the
//    lower triangle (c <= r), N*(N+1)/2 elements. Ports are the same in both
//    builds.
//
// Ports
//    clk        in   single clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    in_valid   in   one-cycle pulse, in_real/in_imag hold a full matrix
//    in_real    in   N*N*W flat real parts, element (r,c) at [(r*N+c)*W +: W]
//    in_imag    in   N*N*W flat imaginary parts, same packing
//    out_valid  out  current element outputs are valid
//    out_ready  in   consumer accepts the current element
//    out_real   out  W-bit real part of current element
//    out_imag   out  W-bit imaginary part of current element
//    out_row    out  row of current element
//    out_col    out  column of current element
//    out_last   out  current element is the final one of the matrix
//    busy       out  a matrix is held / streaming
//    overrun    out  sticky: an in_valid pulse was dropped (cleared by reset)
module result_streamer #(
   parameter int N = 8,
   parameter int W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [N*N*W-1:0]         in_real,
   input  logic [N*N*W-1:0]         in_imag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [W-1:0]             out_real,
   output logic [W-1:0]             out_imag,
   output logic [$clog2(N)-1:0]     out_row,
   output logic [$clog2(N)-1:0]     out_col,
   output logic                     out_last,
   output logic                     busy,
   output logic                     overrun
);

   localparam int IW = $clog2(N);

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t             state_q,    state_d;
   logic [N*N*W-1:0]   mat_re_q,   mat_re_d;
   logic [N*N*W-1:0]   mat_im_q,   mat_im_d;
   logic [IW-1:0]      row_q,      row_d;
   logic [IW-1:0]      col_q,      col_d;
   logic               out_valid_q, out_valid_d;
   logic               out_last_q, out_last_d;
   logic [W-1:0]       out_real_q, out_real_d;
   logic [W-1:0]       out_imag_q, out_imag_d;
   logic               overrun_q,  overrun_d;

   logic               xfer;
   logic               capture;
   logic [IW-1:0]      nxt_row;
   logic [IW-1:0]      nxt_col;

   function automatic logic [W-1:0] elem(input logic [N*N*W-1:0] m,
                                         input logic [IW-1:0]    r,
                                         input logic [IW-1:0]    c);
      return m[(int'(r) * N + int'(c)) * W +: W];
   endfunction

   // Coordinates of the element following (row_q, col_q) in stream order.
   always_comb begin
      nxt_row = row_q;
      nxt_col = col_q + IW'(1);
`ifdef RESULT_STREAMER_HERMITIAN_EN
      if (col_q == row_q) begin
`else
      if (col_q == IW'(N - 1)) begin
`endif
         nxt_row = row_q + IW'(1);
         nxt_col = '0;
      end
   end

   // Output registers are loaded directly with the next element so every
   // output is a flop; a capture loads element (0,0) straight from in_*.
   always_comb begin
      state_d     = state_q;
      mat_re_d    = mat_re_q;
      mat_im_d    = mat_im_q;
      row_d       = row_q;
      col_d       = col_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_real_d  = out_real_q;
      out_imag_d  = out_imag_q;
      overrun_d   = overrun_q;

      xfer    = (state_q == STREAM) && out_ready;
      capture = in_valid && ((state_q == IDLE) || (xfer && out_last_q));

      if (capture) begin
         state_d     = STREAM;
         mat_re_d    = in_real;
         mat_im_d    = in_imag;
         row_d       = '0;
         col_d       = '0;
         out_valid_d = 1'b1;
         out_last_d  = (N == 1);
         out_real_d  = in_real[W-1:0];
         out_imag_d  = in_imag[W-1:0];
      end else if (xfer) begin
         if (out_last_q) begin
            state_d     = IDLE;
            row_d       = '0;
            col_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_real_d  = '0;
            out_imag_d  = '0;
         end else begin
            row_d       = nxt_row;
            col_d       = nxt_col;
            out_last_d  = (nxt_row == IW'(N - 1)) && (nxt_col == IW'(N - 1));
            out_real_d  = elem(mat_re_q, nxt_row, nxt_col);
            out_imag_d  = elem(mat_im_q, nxt_row, nxt_col);
         end
      end

      // Any pulse during STREAM other than on the final transfer is dropped.
      if (in_valid && (state_q == STREAM) && !(xfer && out_last_q)) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mat_re_q    <= '0;
         mat_im_q    <= '0;
         row_q       <= '0;
         col_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_real_q  <= '0;
         out_imag_q  <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mat_re_q    <= mat_re_d;
         mat_im_q    <= mat_im_d;
         row_q       <= row_d;
         col_q       <= col_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_real_q  <= out_real_d;
         out_imag_q  <= out_imag_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_real  = out_real_q;
   assign out_imag  = out_imag_q;
   assign out_row   = row_q;
   assign out_col   = col_q;
   assign busy      = (state_q == STREAM);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_result_streamer.sv
// tb_result_streamer
//    Self-checking bench for result_streamer (N=8, W=32). Matrices use
//    real = base + r*8 + c + 1, imag = base + r*8 + c + 101. Expected
//    elements are queued when a matrix is handed over and popped on each
//    accepted transfer.
module tb_result_streamer;

   localparam int N  = 8;
   localparam int W  = 32;
   localparam int IW = $clog2(N);
`ifdef RESULT_STREAMER_HERMITIAN_EN
   localparam int TOTAL = N * (N + 1) / 2;
`else
   localparam int TOTAL = N * N;
`endif

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic [N*N*W-1:0]   in_real;
   logic [N*N*W-1:0]   in_imag;
   logic               out_valid;
   logic               out_ready;
   logic [W-1:0]       out_real;
   logic [W-1:0]       out_imag;
   logic [IW-1:0]      out_row;
   logic [IW-1:0]      out_col;
   logic               out_last;
   logic               busy;
   logic               overrun;

   result_streamer #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_real   (in_real),
      .in_imag   (in_imag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_real  (out_real),
      .out_imag  (out_imag),
      .out_row   (out_row),
      .out_col   (out_col),
      .out_last  (out_last),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]  re;
      logic [W-1:0]  im;
      logic [IW-1:0] row;
      logic [IW-1:0] col;
      logic          last;
   } elem_t;

   typedef struct {
      logic [31:0]   base;
      logic [11:0]   pat;      // out_ready pattern, bit n%plen used in cycle n
      int            plen;
      int            inj_at;   // transfer index for a second pulse, -1 none
      logic [31:0]   inj_base;
      bit            inj_ok;   // second pulse expected to be accepted
      int            exp_cnt;
      logic          exp_ovr;
   } vec_t;

   elem_t  exp_q[$];
   int     checks   = 0;
   int     failures = 0;
   int     xfer_cnt = 0;
   bit     hold_pending = 1'b0;
   elem_t  held;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [N*N*W-1:0] mk(input logic [31:0] base, input bit imag);
      logic [N*N*W-1:0] m;
      m = '0;
      for (int i = 0; i < N * N; i++) begin
         m[i*W +: W] = base + 32'(i) + (imag ? 32'd101 : 32'd1);
      end
      return m;
   endfunction

   task automatic push_matrix(input logic [31:0] base);
      elem_t e;
      int    n;
      n = 0;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
`ifdef RESULT_STREAMER_HERMITIAN_EN
            if (c > r) continue;
`endif
            n++;
            e.re   = base + 32'(r * N + c) + 32'd1;
            e.im   = base + 32'(r * N + c) + 32'd101;
            e.row  = IW'(r);
            e.col  = IW'(c);
            e.last = (n == TOTAL);
            exp_q.push_back(e);
         end
      end
   endtask

   // Called at a falling edge with inputs already driven; checks the
   // presented outputs, then advances to the next falling edge.
   task automatic cycle();
      elem_t e;
      chk("valid", out_valid, exp_q.size() != 0);
      chk("busy",  busy,      exp_q.size() != 0);
      if (hold_pending) begin
         chk("hold", {out_real, out_imag, out_row, out_col, out_last},
                     {held.re, held.im, held.row, held.col, held.last});
      end
      hold_pending = 1'b0;
      if (out_valid && out_ready && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("elem", {out_real, out_imag, out_row, out_col, out_last},
                     {e.re, e.im, e.row, e.col, e.last});
         xfer_cnt++;
      end else if (out_valid && !out_ready) begin
         held.re = out_real;  held.im = out_imag;
         held.row = out_row;  held.col = out_col;
         held.last = out_last;
         hold_pending = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pulse(input logic [31:0] base);
      in_real  = mk(base, 1'b0);
      in_imag  = mk(base, 1'b1);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      push_matrix(base);
   endtask

   task automatic run_vec(input vec_t v);
      int start, n;
      bit inj_done, do_push;
      start = xfer_cnt;
      n = 0;
      inj_done = 1'b0;
      do_push = 1'b0;
      out_ready = v.pat[0];
      pulse(v.base);
      while (exp_q.size() > 0 && n < 3000) begin
         out_ready = v.pat[n % v.plen];
         if (!inj_done && v.inj_at >= 0 && xfer_cnt == start + v.inj_at
             && out_valid && out_ready) begin
            in_real  = mk(v.inj_base, 1'b0);
            in_imag  = mk(v.inj_base, 1'b1);
            in_valid = 1'b1;
            inj_done = 1'b1;
            do_push  = v.inj_ok;
         end
         cycle();
         in_valid = 1'b0;
         if (do_push) push_matrix(v.inj_base);
         do_push = 1'b0;
         n++;
      end
      if (exp_q.size() > 0) begin
         chk("timeout", 128'(exp_q.size()), 128'd0);
         exp_q.delete();
      end
      chk("idle_after", {out_valid, busy}, 2'b00);
      chk("count", 128'(xfer_cnt - start), 128'(v.exp_cnt));
      chk("overrun", overrun, v.exp_ovr);
   endtask

   vec_t vecs[6];

   initial begin
      // base, ready pattern, plen, inj_at, inj_base, inj_ok, count, overrun
      vecs[0] = '{32'd0,          12'hFFF,             1, -1,        32'd0,    1'b0, TOTAL,     1'b0};
      vecs[1] = '{32'd0,          12'b0000_0000_1001,  3, -1,        32'd0,    1'b0, TOTAL,     1'b0};
      vecs[2] = '{32'd500,        12'b1011_0110_1101, 12, -1,        32'd0,    1'b0, TOTAL,     1'b0};
      vecs[3] = '{32'hFFFF_FFC0,  12'b0000_0000_0110,  4, -1,        32'd0,    1'b0, TOTAL,     1'b0};
      vecs[4] = '{32'd0,          12'hFFF,             1, TOTAL - 1, 32'd1000, 1'b1, 2 * TOTAL, 1'b0};
      vecs[5] = '{32'd0,          12'hFFF,             1, 10,        32'd2000, 1'b0, TOTAL,     1'b1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_real   = '0;
      in_imag   = '0;
      @(negedge clk);
      chk("reset_state", {out_valid, out_last, busy, overrun, out_real, out_imag, out_row, out_col}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle();

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i]);
      end

      // overrun is sticky across a clean run
      run_vec('{32'd50, 12'hFFF, 1, -1, 32'd0, 1'b0, TOTAL, 1'b1});

      // Reset in the middle of a stream: outputs clear immediately.
      out_ready = 1'b1;
      pulse(32'd0);
      for (int n = 0; n < 200 && xfer_cnt % TOTAL != 20 % TOTAL; n++) begin
         cycle();
      end
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset", {out_valid, out_last, busy, overrun, out_real, out_imag, out_row, out_col}, '0);
      exp_q.delete();
      hold_pending = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 4; n++) begin
         cycle();
      end
      run_vec('{32'd7, 12'b0000_0000_0101, 3, -1, 32'd0, 1'b0, TOTAL, 1'b0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

endmodule
